// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : 640x480@60 raster timing constants, derived totals, coordinate
//             width, sync polarity and the registered output bundle type.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

   // Horizontal timing in pixels
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;

   // Vertical timing in lines
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   // Both totals must stay at or below 1024 to fit the coordinate width
   localparam int COORD_W = 10;

   // 1 = sync pulses are driven low
   localparam int VGA_SYNC_ACTIVE_LOW = 1;

   // Everything the timing generator drives, registered together
   typedef struct packed {
      logic               hsync;
      logic               vsync;
      logic               display_enable;
      logic               line_start;
      logic               frame_start;
      logic [COORD_W-1:0] pixel_x;
      logic [COORD_W-1:0] pixel_y;
   } vga_out_t;

   // Output bundle with syncs at their idle level and everything else low
   function automatic vga_out_t vga_idle(input logic sync_idle);
      vga_out_t o;
      o       = '0;
      o.hsync = sync_idle;
      o.vsync = sync_idle;
      return o;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_generator_axis.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axis_counter
//  Purpose  : One raster axis: wrapping position counter plus active-region
//             and sync-window decode of the current count.
//  Revision : 1.0  initial release
// ============================================================================
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   output logic [COORD_W-1:0] cnt,
   output logic               wrap,
   output logic               active,
   output logic               sync_window
);

   localparam int c_total      = ACTIVE + FP + SYNC + BP;
   localparam int c_sync_start = ACTIVE + FP;
   localparam int c_sync_end   = ACTIVE + FP + SYNC;

   logic [COORD_W-1:0] r_cnt;

   // Position counter: advances on inc, returns to 0 after the last position
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (inc) begin
         r_cnt <= wrap ? '0 : r_cnt + COORD_W'(1);
      end
   end

   // wrap flags the last position so the next increment returns to zero
   assign cnt         = r_cnt;
   assign wrap        = (int'(r_cnt) == c_total - 1);
   assign active      = (int'(r_cnt) < ACTIVE);
   assign sync_window = (int'(r_cnt) >= c_sync_start) && (int'(r_cnt) < c_sync_end);

endmodule
`default_nettype wire

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_generator
//  Purpose  : Raster timing source: h/v counters (stage A) decoded into a
//             single register bank (stage B) of syncs, enable, coordinates
//             and line/frame start pulses, all mutually aligned.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_generator
   import vga_pkg::*;
#(
   parameter int H_ACTIVE        = VGA_H_ACTIVE,
   parameter int H_FP            = VGA_H_FP,
   parameter int H_SYNC          = VGA_H_SYNC,
   parameter int H_BP            = VGA_H_BP,
   parameter int V_ACTIVE        = VGA_V_ACTIVE,
   parameter int V_FP            = VGA_V_FP,
   parameter int V_SYNC          = VGA_V_SYNC,
   parameter int V_BP            = VGA_V_BP,
   parameter int SYNC_ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW
)(
   input  logic               pixel_clk,
   input  logic               reset,
   input  logic               pixel_ce,
   output logic               hsync,
   output logic               vsync,
   output logic               display_enable,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               line_start,
   output logic               frame_start
);

   // Level the sync pins sit at outside their pulse windows
   localparam logic c_sync_idle = (SYNC_ACTIVE_LOW != 0);

   logic [COORD_W-1:0] w_h_cnt;
   logic [COORD_W-1:0] w_v_cnt;
   logic               w_h_wrap;
   logic               w_h_active;
   logic               w_h_sync;
   logic               w_v_inc;
   logic               w_v_active;
   logic               w_v_sync;
   logic               w_v_wrap_unused;
   vga_out_t           w_next;
   vga_out_t           r_out;

   // The vertical axis steps once per line, on the enabled edge that ends it
   assign w_v_inc = w_h_wrap & pixel_ce;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk         (pixel_clk),
      .reset       (reset),
      .inc         (pixel_ce),
      .cnt         (w_h_cnt),
      .wrap        (w_h_wrap),
      .active      (w_h_active),
      .sync_window (w_h_sync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk         (pixel_clk),
      .reset       (reset),
      .inc         (w_v_inc),
      .cnt         (w_v_cnt),
      .wrap        (w_v_wrap_unused),
      .active      (w_v_active),
      .sync_window (w_v_sync)
   );

   // Decode the current counter position into the next output bundle
   always_comb begin
      w_next                = vga_idle(c_sync_idle);
      w_next.hsync          = w_h_sync ^ c_sync_idle;
      w_next.vsync          = w_v_sync ^ c_sync_idle;
      w_next.display_enable = w_h_active & w_v_active;
      w_next.line_start     = (w_h_cnt == '0);
      w_next.frame_start    = (w_h_cnt == '0) && (w_v_cnt == '0);
      w_next.pixel_x        = w_h_cnt;
      w_next.pixel_y        = w_v_cnt;
   end

   // Output register bank: loads only on enabled edges, so pulses last one ce period
   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         r_out <= vga_idle(c_sync_idle);
      end else if (pixel_ce) begin
         r_out <= w_next;
      end
   end

   assign hsync          = r_out.hsync;
   assign vsync          = r_out.vsync;
   assign display_enable = r_out.display_enable;
   assign pixel_x        = r_out.pixel_x;
   assign pixel_y        = r_out.pixel_y;
   assign line_start     = r_out.line_start;
   assign frame_start    = r_out.frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_generator
//  Purpose  : Scoreboard bench: a default 640x480 instance (active-low syncs)
//             and a reduced-size instance (active-high syncs) share clock,
//             reset and clock enable; a behavioural raster model predicts
//             every sampled output bundle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_generator;

   // Reduced raster for instance B: 32 x 20 total, 16 x 12 active
   localparam int B_HA = 16, B_HFP = 4, B_HS = 6, B_HBP = 6;
   localparam int B_VA = 12, B_VFP = 2, B_VS = 2, B_VBP = 4;

   typedef struct {
      int ha, hfp, hsw, hbp;
      int va, vfp, vsw, vbp;
      bit sal;
   } cfg_t;

   typedef struct {
      logic [24:0] a;
      logic [24:0] b;
   } exp_t;

   logic       pixel_clk = 1'b0;
   logic       reset     = 1'b1;
   logic       pixel_ce  = 1'b0;

   logic       a_hsync, a_vsync, a_de, a_ls, a_fs;
   logic [9:0] a_x, a_y;
   logic       b_hsync, b_vsync, b_de, b_ls, b_fs;
   logic [9:0] b_x, b_y;
   logic [24:0] a_obs, b_obs;

   assign a_obs = {a_hsync, a_vsync, a_de, a_ls, a_fs, a_x, a_y};
   assign b_obs = {b_hsync, b_vsync, b_de, b_ls, b_fs, b_x, b_y};

   always #5 pixel_clk = ~pixel_clk;

   vga_timing_generator u_dut_a (
      .pixel_clk      (pixel_clk),
      .reset          (reset),
      .pixel_ce       (pixel_ce),
      .hsync          (a_hsync),
      .vsync          (a_vsync),
      .display_enable (a_de),
      .pixel_x        (a_x),
      .pixel_y        (a_y),
      .line_start     (a_ls),
      .frame_start    (a_fs)
   );

   vga_timing_generator #(
      .H_ACTIVE (B_HA), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HBP),
      .V_ACTIVE (B_VA), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VBP),
      .SYNC_ACTIVE_LOW (0)
   ) u_dut_b (
      .pixel_clk      (pixel_clk),
      .reset          (reset),
      .pixel_ce       (pixel_ce),
      .hsync          (b_hsync),
      .vsync          (b_vsync),
      .display_enable (b_de),
      .pixel_x        (b_x),
      .pixel_y        (b_y),
      .line_start     (b_ls),
      .frame_start    (b_fs)
   );

   int   n_total = 0;
   int   n_pass  = 0;
   exp_t sb_q[$];
   cfg_t ca, cb;
   int   ah, av, bh, bv;
   logic [24:0] la, lb;

   // Per-sample statistics, cleared at the start of each measured run
   bit stats_on = 1'b0;
   int n_samp, b_win;
   int a_hs_act, a_hs_first, a_hs_last, a_ls_t, a_ls_period, a_de_fall_x;
   int b_vs_act, b_de_cnt, b_fs_cnt, b_fs_t, b_fs_t1, b_fs_period;
   logic a_ls_prev, a_de_prev, b_fs_prev;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [24:0] decode(input cfg_t c, input int h, input int v);
      logic hw, vw, de;
      hw = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw);
      vw = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw);
      de = (h < c.ha) && (v < c.va);
      return {hw ^ c.sal, vw ^ c.sal, de, h == 0, (h == 0) && (v == 0), h[9:0], v[9:0]};
   endfunction

   function automatic logic [24:0] idle(input cfg_t c);
      return {c.sal, c.sal, 23'd0};
   endfunction

   // Model of one clock edge with the given inputs; pushes the predicted outputs
   task automatic model_step(input logic ce_v, input logic rst_v);
      exp_t e;
      if (rst_v) begin
         ah = 0; av = 0; bh = 0; bv = 0;
         la = idle(ca); lb = idle(cb);
      end else if (ce_v) begin
         la = decode(ca, ah, av);
         lb = decode(cb, bh, bv);
         ah++;
         if (ah == ca.ha + ca.hfp + ca.hsw + ca.hbp) begin
            ah = 0; av++;
            if (av == ca.va + ca.vfp + ca.vsw + ca.vbp) av = 0;
         end
         bh++;
         if (bh == cb.ha + cb.hfp + cb.hsw + cb.hbp) begin
            bh = 0; bv++;
            if (bv == cb.va + cb.vfp + cb.vsw + cb.vbp) bv = 0;
         end
      end
      e.a = la;
      e.b = lb;
      sb_q.push_back(e);
   endtask

   task automatic clear_stats(input int win);
      stats_on = 1'b1; n_samp = 0; b_win = win;
      a_hs_act = 0; a_hs_first = -1; a_hs_last = -1; a_ls_t = -1; a_ls_period = -1;
      a_de_fall_x = -1;
      b_vs_act = 0; b_de_cnt = 0; b_fs_cnt = 0; b_fs_t = -1; b_fs_t1 = -1; b_fs_period = -1;
      a_ls_prev = 1'b0; a_de_prev = 1'b0; b_fs_prev = 1'b0;
   endtask

   // One clock: check the previous edge's outputs, then drive inputs for the next
   task automatic tick(input logic ce_v, input logic rst_v);
      exp_t e;
      @(negedge pixel_clk);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("cycle A", 32'(a_obs), 32'(e.a));
         chk("cycle B", 32'(b_obs), 32'(e.b));
      end
      if (stats_on) begin
         if (n_samp < 800 && a_hsync == 1'b0) begin
            a_hs_act++;
            if (a_hs_first < 0) a_hs_first = int'(a_x);
            a_hs_last = int'(a_x);
         end
         if (a_ls && !a_ls_prev) begin
            if (a_ls_t >= 0) a_ls_period = n_samp - a_ls_t;
            a_ls_t = n_samp;
         end
         if (!a_de && a_de_prev && a_de_fall_x < 0) a_de_fall_x = int'(a_x);
         if (n_samp < b_win) begin
            if (b_vsync) b_vs_act++;
            if (b_de)    b_de_cnt++;
            if (b_fs)    b_fs_cnt++;
         end
         if (b_fs && !b_fs_prev) begin
            if (b_fs_t >= 0) b_fs_period = n_samp - b_fs_t;
            else             b_fs_t1 = n_samp;
            b_fs_t = n_samp;
         end
         a_ls_prev = a_ls; a_de_prev = a_de; b_fs_prev = b_fs;
         n_samp++;
      end
      reset    = rst_v;
      pixel_ce = ce_v;
      model_step(ce_v, rst_v);
   endtask

   initial begin
      ca = '{ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33, sal: 1'b1};
      cb = '{ha: B_HA, hfp: B_HFP, hsw: B_HS, hbp: B_HBP,
             va: B_VA, vfp: B_VFP, vsw: B_VS, vbp: B_VBP, sal: 1'b0};
      ah = 0; av = 0; bh = 0; bv = 0;
      la = idle(ca); lb = idle(cb);

      // Held in reset with the enable low
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
      #1;
      chk("reset A", 32'(a_obs), 32'(idle(ca)));
      chk("reset B", 32'(b_obs), 32'(idle(cb)));

      // Release with a continuous enable: two full A lines, 2.5 B frames
      tick(1'b1, 1'b0);
      clear_stats(640);
      for (int i = 0; i < 1600; i++) tick(1'b1, 1'b0);
      chk("A hsync width", a_hs_act, 96);
      chk("A hsync first x", a_hs_first, 656);
      chk("A hsync last x", a_hs_last, 751);
      chk("A line period", a_ls_period, 800);
      chk("A de fall x", a_de_fall_x, 640);
      chk("B vsync width", b_vs_act, 64);
      chk("B de count", b_de_cnt, 192);
      chk("B frame period", b_fs_period, 640);
      chk("B frame pulses", b_fs_cnt, 1);
      chk("B first frame", b_fs_t1, 0);

      // Move mid-line, then assert reset between clock edges
      for (int i = 0; i < 300; i++) tick(1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("async reset A", 32'(a_obs), 32'(idle(ca)));
      chk("async reset B", 32'(b_obs), 32'(idle(cb)));
      sb_q.delete();
      model_step(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);

      // Release with the enable at half rate
      tick(1'b1, 1'b0);
      stats_on = 1'b0;
      clear_stats(1280);
      for (int i = 1; i <= 2600; i++) tick((i % 2) == 0, 1'b0);
      chk("A line period half rate", a_ls_period, 1600);
      chk("B frame period half rate", b_fs_period, 1280);
      chk("B frame pulse clocks", b_fs_cnt, 2);
      chk("B first frame half rate", b_fs_t1, 0);
      chk("B vsync clocks half rate", b_vs_act, 128);
      chk("B de clocks half rate", b_de_cnt, 384);

      tick(1'b0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
